ram_portb_arbiter: RTL and testbench
====================================

Name: ram_portb_arbiter

Overview:
- Shares the read/write port (port B) of the dual-port instruction/data RAM between two requesters: requester 0 (core data-memory port) and requester 1 (debug/loader port).
- Round-robin arbitration, one transaction per cycle, with an optional bus lock for atomic sequences.
- Sits between the requesters and the RAM's addrb/renb/wenb/webb/datab/qb pins.
- Routes the RAM's 1-cycle read data back to the owning requester.

Parameters:
- p_ADDR_BITS, 32, word address width; matches the RAM addrb.
- p_DATA_BITS, 32, data width.
- p_STRB_BITS, p_DATA_BITS/8, byte-strobe width.
- p_LOCK_TIMEOUT, 16, idle cycles after which a held lock is forcibly released. Must be ≥1; the counter is $clog2(p_LOCK_TIMEOUT+1) bits.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous assert, active-low
- req0/req1  in  1  request valid
- lock0/lock1  in  1  hold the port after this transaction
- wen0/wen1  in  1  1 = write, 0 = read
- addr0/addr1  in  p_ADDR_BITS  word address
- strb0/strb1  in  p_STRB_BITS  write byte enables
- wdata0/wdata1  in  p_DATA_BITS  write data
- gnt0/gnt1  out  1  request accepted this cycle (combinational)
- rvalid0/rvalid1  out  1  response valid (read data or write ack)
- rdata0/rdata1  out  p_DATA_BITS  read data; zero for write acks
- addrb  out  p_ADDR_BITS  to RAM
- renb, wenb  out  1  to RAM
- webb  out  p_STRB_BITS  to RAM
- datab  out  p_DATA_BITS  to RAM
- qb  in  p_DATA_BITS  RAM read data, valid 1 cycle after renb

Behaviour:
- Reset values (async on rst_n low):
  - state = IDLE, last_gnt = 1 (so requester 0 wins the first tie), lock timer = 0.
  - Response tag registers: rsp_vld = 0, rsp_id = 0, rsp_rd = 0.
  - Result: rvalid*/gnt*/renb/wenb = 0 and rdata* = 0 while in reset.
- States:
  - IDLE: both requesters are eligible. Single request: it is granted. Both requesting: the one not equal to last_gnt wins. Grant updates last_gnt.
  - LOCK0 / LOCK1: only the owner is eligible; the other's gnt stays 0 even when its req is high.
- Transitions:
  - IDLE -> LOCKn when requester n is granted with lockn = 1.
  - LOCKn -> IDLE when the owner is granted with lockn = 0 (that transaction still completes).
  - LOCKn -> IDLE when the owner has req low for p_LOCK_TIMEOUT consecutive cycles. The timer clears on any owner request.
  - LOCKn -> LOCKn on an owner grant with lockn = 1.
- Issue:
  - In the grant cycle, the RAM pins are driven combinationally from the winner: addrb = addr, renb = ~wen, wenb = wen, webb = wen ? strb : 0, datab = wdata.
  - With no grant: renb = wenb = 0 and webb = 0. addrb/datab hold the requester-0 values (don't-care).
- Response (fixed latency 1):
  - The cycle after a grant, rvalidN = 1 for the winner only.
  - rdataN = qb for reads, 0 for writes; the non-owner's rdata = 0.
  - No response backpressure: requesters must sink rvalid.
- Throughput: back-to-back grants every cycle. Grants alternate under continuous contention in IDLE.
- Read-after-write to the same address in consecutive cycles returns the new data; the RAM write completes before the next-cycle read samples.
- Simultaneous lock request: only the winner's lock is honoured. The loser's lock bit is ignored until it is granted.
- Reset mid-lock or mid-response: the lock is dropped, the pending rvalid is discarded, and the post-reset grant order restarts with requester 0.
- Unknown (X) requests are not assumed; req low means the other inputs are ignored.

Optional Feature:
- RAM_ARB_FIXED_PRIO_EN
  - Defined: IDLE arbitration is fixed priority, requester 0 always beats requester 1. last_gnt is not used; lock and timeout behaviour are unchanged.
  - Undefined: round-robin as described above.

Test Plan:
- Reset, then req0 = req1 = 1, both reads, held 4 cycles -> gnt order 0,1,0,1; each rvalid arrives exactly 1 cycle after its gnt. Preloaded mem[3] = 0xDEADBEEF returned on rdata0 for addr0 = 3.
- Requester 1 writes addr 5, strb = 4'b0101, wdata = 0x11223344 over mem = 0xAABBCCDD, then reads addr 5 next cycle -> rdata1 = 0xAA22CC44. The write-cycle rvalid1 has rdata1 = 0.
- Requester 0 issues with lock0 = 1 for 3 transactions while req1 is held high -> gnt1 stays 0. The 3rd transaction with lock0 = 0 frees the port, and gnt1 = 1 on the next cycle.
- Requester 1 locks, then drops req1 while req0 is high -> gnt0 stays 0 for exactly p_LOCK_TIMEOUT (16) cycles, and gnt0 = 1 on cycle 17.
- Assert rst_n low in the cycle after a locked read grant -> rvalid0 = 0 immediately (async) and the lock is released. After reset, simultaneous requests grant requester 0 first.
- With RAM_ARB_FIXED_PRIO_EN defined, continuous req0 = req1 = 1 -> gnt0 every cycle and gnt1 never.

Source files
------------

// File: rtl/ram_portb_arbiter.sv
// rtl/ram_portb_arbiter.sv - round-robin port-B RAM arbiter with lock and lock timeout (RAM_ARB_FIXED_PRIO_EN selects fixed priority)
module ram_portb_arbiter #(
  parameter int p_ADDR_BITS    = 32,
  parameter int p_DATA_BITS    = 32,
  parameter int p_STRB_BITS    = p_DATA_BITS / 8,
  parameter int p_LOCK_TIMEOUT = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   req0,
  input  logic                   req1,
  input  logic                   lock0,
  input  logic                   lock1,
  input  logic                   wen0,
  input  logic                   wen1,
  input  logic [p_ADDR_BITS-1:0] addr0,
  input  logic [p_ADDR_BITS-1:0] addr1,
  input  logic [p_STRB_BITS-1:0] strb0,
  input  logic [p_STRB_BITS-1:0] strb1,
  input  logic [p_DATA_BITS-1:0] wdata0,
  input  logic [p_DATA_BITS-1:0] wdata1,
  output logic                   gnt0,
  output logic                   gnt1,
  output logic                   rvalid0,
  output logic                   rvalid1,
  output logic [p_DATA_BITS-1:0] rdata0,
  output logic [p_DATA_BITS-1:0] rdata1,
  output logic [p_ADDR_BITS-1:0] addrb,
  output logic                   renb,
  output logic                   wenb,
  output logic [p_STRB_BITS-1:0] webb,
  output logic [p_DATA_BITS-1:0] datab,
  input  logic [p_DATA_BITS-1:0] qb
);

  localparam int TW = $clog2(p_LOCK_TIMEOUT + 1);
  localparam logic [TW-1:0] TIMER_LAST = TW'(p_LOCK_TIMEOUT - 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_LOCK0 = 2'd1;
  localparam logic [1:0] ST_LOCK1 = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          rsp_vld_q, rsp_vld_d;
  logic          rsp_id_q, rsp_id_d;
  logic          rsp_rd_q, rsp_rd_d;
  logic          pick1;
  logic          raw_gnt0, raw_gnt1;
  logic          any_gnt, sel_wen;

`ifdef RAM_ARB_FIXED_PRIO_EN
  // Requester 0 always wins a tie in IDLE
  assign pick1 = 1'b0;
`else
  logic last_gnt_q, last_gnt_d;

  // Tie goes to whichever requester was not granted last
  assign pick1 = ~last_gnt_q;

  // Remember the most recent winner for round-robin ordering
  always_comb begin
    last_gnt_d = last_gnt_q;
    if (gnt0) last_gnt_d = 1'b0;
    if (gnt1) last_gnt_d = 1'b1;
  end

  // Last-grant register; reset to 1 so requester 0 wins the first tie
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) last_gnt_q <= 1'b1;
    else        last_gnt_q <= last_gnt_d;
  end
`endif

  // Grant selection: both eligible in IDLE, only the owner while locked
  always_comb begin
    raw_gnt0 = 1'b0;
    raw_gnt1 = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req0 && req1) begin
          raw_gnt1 = pick1;
          raw_gnt0 = ~pick1;
        end else begin
          raw_gnt0 = req0;
          raw_gnt1 = req1;
        end
      end
      ST_LOCK0: raw_gnt0 = req0;
      ST_LOCK1: raw_gnt1 = req1;
      default: ;
    endcase
  end

  // No grants (and so no RAM strobes) are issued while reset is held
  assign gnt0 = rst_n & raw_gnt0;
  assign gnt1 = rst_n & raw_gnt1;

  assign any_gnt = gnt0 | gnt1;
  assign sel_wen = gnt1 ? wen1 : wen0;

  // Drive the RAM pins from the winner; requester 0 fields when idle
  assign addrb = gnt1 ? addr1 : addr0;
  assign datab = gnt1 ? wdata1 : wdata0;
  assign renb  = any_gnt & ~sel_wen;
  assign wenb  = any_gnt & sel_wen;
  assign webb  = (any_gnt && sel_wen) ? (gnt1 ? strb1 : strb0) : '0;

  // Lock state machine and owner-idle timeout counter
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    case (state_q)
      ST_IDLE: begin
        timer_d = '0;
        if (gnt0 && lock0) state_d = ST_LOCK0;
        if (gnt1 && lock1) state_d = ST_LOCK1;
      end
      ST_LOCK0, ST_LOCK1: begin
        if (state_q == ST_LOCK0 ? req0 : req1) begin
          timer_d = '0;
          if (!(state_q == ST_LOCK0 ? lock0 : lock1)) state_d = ST_IDLE;
        end else if (timer_q == TIMER_LAST) begin
          timer_d = '0;
          state_d = ST_IDLE;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        timer_d = '0;
      end
    endcase
  end

  // Tag the transaction issued this cycle so its response returns next cycle
  always_comb begin
    rsp_vld_d = any_gnt;
    rsp_id_d  = gnt1;
    rsp_rd_d  = any_gnt & ~sel_wen;
  end

  // State, timer and response-tag registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      timer_q   <= '0;
      rsp_vld_q <= 1'b0;
      rsp_id_q  <= 1'b0;
      rsp_rd_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      rsp_vld_q <= rsp_vld_d;
      rsp_id_q  <= rsp_id_d;
      rsp_rd_q  <= rsp_rd_d;
    end
  end

  // Route the RAM read data to the owner; writes are acked with zero data
  assign rvalid0 = rsp_vld_q & ~rsp_id_q;
  assign rvalid1 = rsp_vld_q & rsp_id_q;
  assign rdata0  = (rvalid0 && rsp_rd_q) ? qb : '0;
  assign rdata1  = (rvalid1 && rsp_rd_q) ? qb : '0;

endmodule

// File: tb/tb_ram_portb_arbiter.sv
// tb/tb_ram_portb_arbiter.sv - directed self-checking bench for ram_portb_arbiter
module tb_ram_portb_arbiter;

`ifdef RAM_ARB_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0, req1, lock0, lock1, wen0, wen1;
  logic [31:0] addr0, addr1, wdata0, wdata1;
  logic [3:0]  strb0, strb1;
  logic        gnt0, gnt1, rvalid0, rvalid1;
  logic [31:0] rdata0, rdata1;
  logic [31:0] addrb, datab;
  logic        renb, wenb;
  logic [3:0]  webb;
  logic [31:0] qb = '0;
  logic [31:0] mem [0:63];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ram_portb_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .req1(req1), .lock0(lock0), .lock1(lock1),
    .wen0(wen0), .wen1(wen1), .addr0(addr0), .addr1(addr1),
    .strb0(strb0), .strb1(strb1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata0(rdata0), .rdata1(rdata1),
    .addrb(addrb), .renb(renb), .wenb(wenb), .webb(webb), .datab(datab),
    .qb(qb)
  );

  // Byte-strobed synchronous RAM with 1-cycle read latency
  always @(posedge clk) begin
    if (wenb) begin
      for (int b = 0; b < 4; b++)
        if (webb[b]) mem[addrb[5:0]][8*b +: 8] <= datab[8*b +: 8];
    end
    if (renb) qb <= mem[addrb[5:0]];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic drive0(input logic r, input logic l, input logic w, input logic [31:0] a,
                        input logic [3:0] s, input logic [31:0] d);
    req0 = r; lock0 = l; wen0 = w; addr0 = a; strb0 = s; wdata0 = d;
  endtask

  task automatic drive1(input logic r, input logic l, input logic w, input logic [31:0] a,
                        input logic [3:0] s, input logic [31:0] d);
    req1 = r; lock1 = l; wen1 = w; addr1 = a; strb1 = s; wdata1 = d;
  endtask

  logic e0, p0, p1;

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'h0;
    mem[3] = 32'hDEADBEEF;
    mem[4] = 32'h0BADF00D;
    mem[5] = 32'hAABBCCDD;

    // Reset with both requests pending: nothing may be granted
    rst_n = 1'b0;
    drive0(1'b1, 1'b0, 1'b0, 32'd3, 4'h0, 32'h0);
    drive1(1'b1, 1'b0, 1'b0, 32'd4, 4'h0, 32'h0);
    #7;
    check("rst_gnt0", gnt0, 1'b0);
    check("rst_gnt1", gnt1, 1'b0);
    check("rst_rvalid0", rvalid0, 1'b0);
    check("rst_rvalid1", rvalid1, 1'b0);
    check("rst_renb", renb, 1'b0);
    check("rst_rdata0", rdata0, 32'h0);

    // Contention: alternating grants, responses one cycle later
    @(negedge clk);
    rst_n = 1'b1;
    p0 = 1'b0; p1 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #2;
      e0 = FIXED ? 1'b1 : (i % 2 == 0);
      check("rr_gnt0", gnt0, e0);
      check("rr_gnt1", gnt1, !e0);
      check("rr_addrb", addrb, e0 ? 32'd3 : 32'd4);
      check("rr_rvalid0", rvalid0, p0);
      check("rr_rvalid1", rvalid1, p1);
      check("rr_rdata0", rdata0, p0 ? 32'hDEADBEEF : 32'h0);
      check("rr_rdata1", rdata1, p1 ? 32'h0BADF00D : 32'h0);
      p0 = e0; p1 = !e0;
      @(negedge clk);
    end
    drive0(1'b0, 1'b0, 1'b0, 32'd0, 4'h0, 32'h0);
    drive1(1'b0, 1'b0, 1'b0, 32'd0, 4'h0, 32'h0);
    #2;
    check("rr_last_rvalid0", rvalid0, p0);
    check("rr_last_rvalid1", rvalid1, p1);
    check("rr_idle_renb", renb, 1'b0);
    @(negedge clk);

    // Requester 1 partial write then read-after-write
    drive1(1'b1, 1'b0, 1'b1, 32'd5, 4'b0101, 32'h11223344);
    #2;
    check("wr_gnt1", gnt1, 1'b1);
    check("wr_wenb", wenb, 1'b1);
    check("wr_renb", renb, 1'b0);
    check("wr_webb", webb, 4'b0101);
    check("wr_datab", datab, 32'h11223344);
    @(negedge clk);
    drive1(1'b1, 1'b0, 1'b0, 32'd5, 4'b0000, 32'h0);
    #2;
    check("raw_gnt1", gnt1, 1'b1);
    check("raw_renb", renb, 1'b1);
    check("raw_webb", webb, 4'b0000);
    check("wr_ack_rvalid1", rvalid1, 1'b1);
    check("wr_ack_rdata1", rdata1, 32'h0);
    check("wr_ack_rvalid0", rvalid0, 1'b0);
    @(negedge clk);
    drive1(1'b0, 1'b0, 1'b0, 32'd0, 4'h0, 32'h0);
    #2;
    check("raw_rvalid1", rvalid1, 1'b1);
    check("raw_rdata1", rdata1, 32'hAA22CC44);
    @(negedge clk);

    // Requester 0 holds the port for three transactions
    drive1(1'b1, 1'b0, 1'b0, 32'd4, 4'h0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      drive0(1'b1, (i < 2), 1'b0, 32'd3, 4'h0, 32'h0);
      #2;
      check("lk0_gnt0", gnt0, 1'b1);
      check("lk0_gnt1", gnt1, 1'b0);
      @(negedge clk);
    end
    #2;
    check("lk0_free_gnt1", gnt1, !FIXED);
    check("lk0_free_gnt0", gnt0, FIXED);
    check("lk0_rvalid0", rvalid0, 1'b1);
    check("lk0_rdata0", rdata0, 32'hDEADBEEF);
    @(negedge clk);

    // Requester 1 locks then goes idle: port released after the timeout
    drive0(1'b0, 1'b0, 1'b0, 32'd3, 4'h0, 32'h0);
    drive1(1'b1, 1'b1, 1'b0, 32'd4, 4'h0, 32'h0);
    #2;
    check("to_lock_gnt1", gnt1, 1'b1);
    @(negedge clk);
    drive1(1'b0, 1'b0, 1'b0, 32'd0, 4'h0, 32'h0);
    drive0(1'b1, 1'b0, 1'b0, 32'd3, 4'h0, 32'h0);
    for (int i = 1; i <= 16; i++) begin
      #2;
      check("to_wait_gnt0", gnt0, 1'b0);
      @(negedge clk);
    end
    #2;
    check("to_release_gnt0", gnt0, 1'b1);
    @(negedge clk);

    // Reset right after a locked read grant
    drive0(1'b1, 1'b1, 1'b0, 32'd3, 4'h0, 32'h0);
    #2;
    check("rl_gnt0", gnt0, 1'b1);
    @(negedge clk);
    drive1(1'b1, 1'b0, 1'b0, 32'd4, 4'h0, 32'h0);
    #2;
    check("rl_rvalid0", rvalid0, 1'b1);
    check("rl_rdata0", rdata0, 32'hDEADBEEF);
    rst_n = 1'b0;
    #1;
    check("rl_async_rvalid0", rvalid0, 1'b0);
    check("rl_async_rdata0", rdata0, 32'h0);
    check("rl_async_gnt0", gnt0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    drive0(1'b1, 1'b0, 1'b0, 32'd3, 4'h0, 32'h0);
    #2;
    check("post_rst_gnt0", gnt0, 1'b1);
    check("post_rst_gnt1", gnt1, 1'b0);
    check("post_rst_rvalid0", rvalid0, 1'b0);
    @(negedge clk);
    #2;
    check("post_rst_unlocked_gnt1", gnt1, !FIXED);
    check("post_rst_unlocked_gnt0", gnt0, FIXED);
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
